fp_keystream_extract: RTL

Downstream stage of the floating-point divider in the chaotic-map datapath. Takes the IEEE-754 chaotic state values the divider produces and converts each to unsigned fixed point. Derives one 8-bit keystream byte per value and buffers the bytes in a small FIFO with a valid/ready output for the pixel XOR stage. The divider cannot stall, so this block exposes `almost_full` for issue throttling and a sticky `overflow` flag.

---
 rtl/fp_keystream_extract.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_keystream_extract.sv
// fp_keystream_extract
// ---------------------------------------------------------------------------
// Takes the IEEE-754 chaotic state values from the floating-point divider and
// converts each one to unsigned Q8.24 fixed point (|x| * 2^24, truncated
// toward zero). It derives one keystream byte per value and queues the bytes
// in a small FIFO that feeds the pixel XOR stage.
//
// The divider cannot stall, so this block has no input backpressure.
// Upstream uses `almost_full` to throttle issue. A byte that arrives while the
// FIFO is full is dropped, and the sticky `overflow` flag records it.
//
// Configuration macro: KEY_XOR_FOLD_EN
//   defined   : out_byte = fixed[23:16] ^ fixed[15:8] ^ fixed[7:0]
//   undefined : out_byte = fixed[23:16]
//
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   clear       : synchronous flush of pipeline, FIFO and overflow
//   in_valid    : in_data is valid this cycle
//   in_data     : IEEE-754 operand (PRECISION bits)
//   out_valid   : FIFO head byte available (registered)
//   out_ready   : consumer accepts the head byte
//   out_byte    : FIFO head byte, 0x00 while empty
//   level       : FIFO occupancy (registered)
//   almost_full : level >= AFULL_LEVEL (registered)
//   overflow    : sticky, a converted byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module fp_keystream_extract #(
    parameter int PRECISION   = 32,
    parameter int EXPONENT    = 8,
    parameter int FRACTION    = 23,
    parameter int BIAS        = 127,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [PRECISION-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int MW = FRACTION + 1;
    localparam int SW = EXPONENT + 3;
    localparam int FW = 32;
    // s = e - BIAS - FRACTION + 24, folded into a single constant offset.
    localparam logic signed [SW-1:0] SHIFT_OFFSET = SW'(BIAS + FRACTION - 24);

    // Stage A state
    logic                 valid_a_q, valid_a_d;
    logic                 exp_zero_a_q, exp_zero_a_d;
    logic                 exp_ones_a_q, exp_ones_a_d;
    logic [MW-1:0]        man_a_q, man_a_d;
    logic signed [SW-1:0] shift_a_q, shift_a_d;

    // Stage B state
    logic                 valid_b_q, valid_b_d;
    logic [7:0]           byte_b_q, byte_b_d;

    // FIFO state
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 out_valid_q, out_valid_d;
    logic                 almost_full_q, almost_full_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           mem_q [DEPTH];
    logic                 mem_we;

    logic [EXPONENT-1:0]  exp_in;
    int                   shift_b;
    logic [FW-1:0]        fixed;
    logic                 full, pop, push_ok, drop;
    logic                 unused_bits;

    assign exp_in = in_data[PRECISION-2 -: EXPONENT];

    // Stage A: split the operand. The sign bit is ignored, which gives |x|.
    // Classify the exponent and compute the signed shift that is applied
    // to the mantissa in Stage B.
    always_comb begin
        valid_a_d    = in_valid && !clear;
        exp_zero_a_d = (exp_in == '0);
        exp_ones_a_d = (exp_in == '1);
        man_a_d      = {1'b1, in_data[FRACTION-1:0]};
        shift_a_d    = $signed({{(SW-EXPONENT){1'b0}}, exp_in}) - SHIFT_OFFSET;
    end

    // Stage B: scale the mantissa into Q8.24.
    // Zero and denormal inputs give 0. Inf/NaN and results wider than
    // 32 bits saturate. Right shifts past the mantissa width give 0.
    always_comb begin
        shift_b = int'(shift_a_q);
        fixed   = '0;
        if (exp_ones_a_q) begin
            fixed = '1;
        end else if (exp_zero_a_q) begin
            fixed = '0;
        end else if (shift_b > FW - MW) begin
            fixed = '1;
        end else if (shift_b >= 0) begin
            fixed = FW'(man_a_q) << shift_b;
        end else if (-shift_b >= MW) begin
            fixed = '0;
        end else begin
            fixed = FW'(man_a_q) >> (-shift_b);
        end

`ifdef KEY_XOR_FOLD_EN
        byte_b_d = fixed[23:16] ^ fixed[15:8] ^ fixed[7:0];
`else
        byte_b_d = fixed[23:16];
`endif
        valid_b_d = valid_a_q && !clear;
    end

    assign unused_bits = ^{in_data[PRECISION-1], fixed[FW-1:24], fixed[15:0]};

    // FIFO control.
    // When the FIFO is full, a write is still accepted if a pop happens on
    // the same edge, because the freed slot is the one being written.
    always_comb begin
        full    = (level_q == LW'(DEPTH));
        pop     = out_valid_q && out_ready;
        push_ok = valid_b_q && (!full || pop);
        drop    = valid_b_q && full && !pop;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            mem_we     = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + PW'(push_ok);
            rd_ptr_d   = rd_ptr_q + PW'(pop);
            level_d    = level_q + LW'(push_ok) - LW'(pop);
            overflow_d = overflow_q | drop;
            mem_we     = push_ok;
        end

        out_valid_d   = (level_d != '0);
        almost_full_d = (level_d >= LW'(AFULL_LEVEL));
    end

    // Control state. All of it returns to idle on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_a_q     <= 1'b0;
            exp_zero_a_q  <= 1'b0;
            exp_ones_a_q  <= 1'b0;
            man_a_q       <= '0;
            shift_a_q     <= '0;
            valid_b_q     <= 1'b0;
            byte_b_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            valid_a_q     <= valid_a_d;
            exp_zero_a_q  <= exp_zero_a_d;
            exp_ones_a_q  <= exp_ones_a_d;
            man_a_q       <= man_a_d;
            shift_a_q     <= shift_a_d;
            valid_b_q     <= valid_b_d;
            byte_b_q      <= byte_b_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    // FIFO storage has no reset. Entries are only observed while
    // out_valid is set.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= byte_b_q;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_byte    = out_valid_q ? mem_q[rd_ptr_q] : 8'h00;
    assign level       = level_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

endmodule
